// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared constants and constant functions for the systolic convolution chain.
//   DATA_SIZE / KERNEL_SIZE : default pixel width and convolution kernel size
//   ACC_WIDTH               : width of a signed convolution result
//   map_dim()               : feature-map dimension after a valid convolution
//   pool_dim()              : pooled dimension for 2x2, stride-2 pooling
//   clog2() / cnt_width()   : counter widths (cnt_width is never below 1)
// No ports.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DATA_SIZE   = 8;
    localparam int KERNEL_SIZE = 3;
    localparam int ACC_WIDTH   = 2 * DATA_SIZE + 5;

    function automatic int map_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int pool_dim(input int m);
        return m / 2;
    endfunction

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/pool_max2.sv
// -----------------------------------------------------------------------------
// pool_max2
// Combinational signed maximum of two IN_WIDTH operands.
// Optional macro SYSTOLIC_MAXPOOL_RELU_EN: both operands are clamped to zero
// when negative before the compare, so y is never negative.
// Because max(relu(a), relu(b)) == relu(max(a, b)), clamping here gives the
// same result as clamping every sample on entry.
// Ports:
//   a, b : signed operands
//   y    : signed maximum (ties return a, which equals b)
// -----------------------------------------------------------------------------
module pool_max2
    import systolic_pkg::*;
#(
    parameter int IN_WIDTH = ACC_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0] a,
    input  logic signed [IN_WIDTH-1:0] b,
    output logic signed [IN_WIDTH-1:0] y
);

    logic signed [IN_WIDTH-1:0] a_c;
    logic signed [IN_WIDTH-1:0] b_c;

    always_comb begin
`ifdef SYSTOLIC_MAXPOOL_RELU_EN
        a_c = a[IN_WIDTH-1] ? '0 : a;
        b_c = b[IN_WIDTH-1] ? '0 : b;
`else
        a_c = a;
        b_c = b;
`endif
        y = (a_c >= b_c) ? a_c : b_c;
    end

endmodule

// File: rtl/systolic_maxpool.sv
// -----------------------------------------------------------------------------
// systolic_maxpool
// 2x2, stride-2 max pooling over a raster-ordered MAP_WIDTH x MAP_HEIGHT
// feature map. Row partial maxima live in a PW-entry line buffer, so no frame
// storage is needed. Odd trailing column/row samples are counted and dropped.
// Optional macro SYSTOLIC_MAXPOOL_RELU_EN (handled in pool_max2): negative
// samples are treated as zero.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-low reset
//   pix_in         : signed convolution result, raster order
//   pix_in_valid   : qualifies pix_in, gaps allowed, no backpressure
//   pool_out       : signed pooled maximum, held between pulses
//   pool_out_valid : one-cycle pulse per pooled result
//   pool_done      : one-cycle pulse with the last pooled result of a frame
// -----------------------------------------------------------------------------
module systolic_maxpool
    import systolic_pkg::*;
#(
    parameter int IN_WIDTH   = ACC_WIDTH,
    parameter int MAP_WIDTH  = 2,
    parameter int MAP_HEIGHT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_WIDTH-1:0] pix_in,
    input  logic                       pix_in_valid,
    output logic signed [IN_WIDTH-1:0] pool_out,
    output logic                       pool_out_valid,
    output logic                       pool_done
);

    localparam int PW = pool_dim(MAP_WIDTH);
    localparam int PH = pool_dim(MAP_HEIGHT);
    localparam int CW = cnt_width(MAP_WIDTH);
    localparam int RW = cnt_width(MAP_HEIGHT);

    logic [CW-1:0]              col_q, col_d;
    logic [RW-1:0]              row_q, row_d;
    logic signed [IN_WIDTH-1:0] hold_q, hold_d;
    logic signed [IN_WIDTH-1:0] line_buf_q [PW];
    logic signed [IN_WIDTH-1:0] line_buf_d [PW];
    logic signed [IN_WIDTH-1:0] pool_out_q, pool_out_d;
    logic                       pool_out_valid_q, pool_out_valid_d;
    logic                       pool_done_q, pool_done_d;

    logic [CW-1:0]              col_half;
    logic signed [IN_WIDTH-1:0] lb_rd;
    logic signed [IN_WIDTH-1:0] h_max;
    logic signed [IN_WIDTH-1:0] v_max;
    logic                       in_region;
    logic                       last_col;
    logic                       last_row;
    logic                       last_window;

    assign col_half    = col_q >> 1;
    assign in_region   = (int'(col_q) < 2 * PW) && (int'(row_q) < 2 * PH);
    assign last_col    = (int'(col_q) == MAP_WIDTH - 1);
    assign last_row    = (int'(row_q) == MAP_HEIGHT - 1);
    assign last_window = (int'(col_q) == 2 * PW - 1) && (int'(row_q) == 2 * PH - 1);

    // Line-buffer read for the current window column.
    always_comb begin
        lb_rd = '0;
        for (int i = 0; i < PW; i++) begin
            if (col_half == CW'(i)) begin
                lb_rd = line_buf_q[i];
            end
        end
    end

    // Horizontal pair max (hold vs. right sample), then vertical max with the
    // partial from the row above.
    pool_max2 #(.IN_WIDTH(IN_WIDTH)) u_max_h (
        .a (hold_q),
        .b (pix_in),
        .y (h_max)
    );

    pool_max2 #(.IN_WIDTH(IN_WIDTH)) u_max_v (
        .a (lb_rd),
        .b (h_max),
        .y (v_max)
    );

    always_comb begin
        col_d            = col_q;
        row_d            = row_q;
        hold_d           = hold_q;
        line_buf_d       = line_buf_q;
        pool_out_d       = pool_out_q;
        pool_out_valid_d = 1'b0;
        pool_done_d      = 1'b0;

        if (pix_in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_region) begin
                if (!col_q[0]) begin
                    hold_d = pix_in;
                end else if (!row_q[0]) begin
                    for (int i = 0; i < PW; i++) begin
                        if (col_half == CW'(i)) begin
                            line_buf_d[i] = h_max;
                        end
                    end
                end else begin
                    pool_out_d       = v_max;
                    pool_out_valid_d = 1'b1;
                    pool_done_d      = last_window;
                end
            end
        end
    end

    // Register stage: counters, hold, line buffer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q            <= '0;
            row_q            <= '0;
            hold_q           <= '0;
            pool_out_q       <= '0;
            pool_out_valid_q <= 1'b0;
            pool_done_q      <= 1'b0;
            for (int i = 0; i < PW; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            col_q            <= col_d;
            row_q            <= row_d;
            hold_q           <= hold_d;
            pool_out_q       <= pool_out_d;
            pool_out_valid_q <= pool_out_valid_d;
            pool_done_q      <= pool_done_d;
            for (int i = 0; i < PW; i++) begin
                line_buf_q[i] <= line_buf_d[i];
            end
        end
    end

    assign pool_out       = pool_out_q;
    assign pool_out_valid = pool_out_valid_q;
    assign pool_done      = pool_done_q;

endmodule

// File: tb/tb_systolic_maxpool.sv
// -----------------------------------------------------------------------------
// tb_systolic_maxpool
// Directed bench for systolic_maxpool with three instances sharing clk/rst:
// a 2x2 map, a 4x4 map and a 3x3 (odd) map. Pooled outputs are collected on
// the falling edge and compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_systolic_maxpool;

    localparam int W = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic signed [W-1:0] pix2, pix3, pix4;
    logic                v2, v3, v4;
    logic signed [W-1:0] po2, po3, po4;
    logic                pv2, pv3, pv4;
    logic                pd2, pd3, pd4;

    systolic_maxpool #(.IN_WIDTH(W), .MAP_WIDTH(2), .MAP_HEIGHT(2)) u_m2 (
        .clk(clk), .rst(rst), .pix_in(pix2), .pix_in_valid(v2),
        .pool_out(po2), .pool_out_valid(pv2), .pool_done(pd2)
    );

    systolic_maxpool #(.IN_WIDTH(W), .MAP_WIDTH(3), .MAP_HEIGHT(3)) u_m3 (
        .clk(clk), .rst(rst), .pix_in(pix3), .pix_in_valid(v3),
        .pool_out(po3), .pool_out_valid(pv3), .pool_done(pd3)
    );

    systolic_maxpool #(.IN_WIDTH(W), .MAP_WIDTH(4), .MAP_HEIGHT(4)) u_m4 (
        .clk(clk), .rst(rst), .pix_in(pix4), .pix_in_valid(v4),
        .pool_out(po4), .pool_out_valid(pv4), .pool_done(pd4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output collection
    longint q2[$], q3[$], q4[$];
    int     d2[$], d3[$], d4[$];
    int     dc3 = 0;
    int     dc4 = 0;

    always @(negedge clk) begin
        if (pv2) begin q2.push_back(longint'(po2)); d2.push_back(int'(pd2)); end
        if (pv3) begin q3.push_back(longint'(po3)); d3.push_back(int'(pd3)); end
        if (pv4) begin q4.push_back(longint'(po4)); d4.push_back(int'(pd4)); end
        if (pd3) dc3++;
        if (pd4) dc4++;
    end

    // Drive one sample to the chosen instance; valid stays high so calls chain
    // back-to-back.
    task automatic send(input int which, input longint v);
        case (which)
            2: begin pix2 = W'(v); v2 = 1'b1; end
            3: begin pix3 = W'(v); v3 = 1'b1; end
            default: begin pix4 = W'(v); v4 = 1'b1; end
        endcase
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        v2 = 1'b0;
        v3 = 1'b0;
        v4 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic longint at(input longint q[$], input int i);
        return (i < q.size()) ? q[i] : -999;
    endfunction

`ifdef SYSTOLIC_MAXPOOL_RELU_EN
    localparam longint NEG_EXP = 0;
`else
    localparam longint NEG_EXP = -5;
`endif

    longint e4 [4] = '{5, 7, 13, 15};
    longint e8 [8] = '{5, 7, 13, 15, 21, 23, 29, 31};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        pix2 = '0; pix3 = '0; pix4 = '0;
        v2 = 1'b0; v3 = 1'b0; v4 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out2", longint'(po2), 0);
        chk("rst_vld2", longint'(pv2), 0);
        chk("rst_done2", longint'(pd2), 0);
        chk("rst_out4", longint'(po4), 0);
        chk("rst_vld4", longint'(pv4), 0);
        rst = 1'b1;
        @(negedge clk);

        // 2x2 basic: -3 7 / 2 -1 -> 7, visible right after the 4th sample edge
        send(2, -3); send(2, 7); send(2, 2); send(2, -1);
        chk("t1_vld", longint'(pv2), 1);
        chk("t1_out", longint'(po2), 7);
        chk("t1_done", longint'(pd2), 1);
        idle(1);
        chk("t1_vld_drop", longint'(pv2), 0);
        chk("t1_done_drop", longint'(pd2), 0);
        chk("t1_hold", longint'(po2), 7);
        idle(1);
        chk("t1_count", q2.size(), 1);
        q2.delete(); d2.delete();

        // All negative 2x2
        send(2, -8); send(2, -5); send(2, -9); send(2, -6);
        idle(2);
        chk("neg_count", q2.size(), 1);
        chk("neg_out", at(q2, 0), NEG_EXP);
        q2.delete(); d2.delete();

        // Signed boundary: 0x100000 is negative at 21 bits
        send(2, 'h100000); send(2, 'h0FFFFF); send(2, 'h100000); send(2, 'h100000);
        idle(2);
        chk("bound_count", q2.size(), 1);
        chk("bound_out", at(q2, 0), 'h0FFFFF);
        q2.delete(); d2.delete();

        // 4x4 map with random gaps
        dc4 = 0;
        for (int i = 0; i < 16; i++) begin
            send(4, i);
            idle($urandom_range(0, 3));
        end
        idle(3);
        chk("gap_count", q4.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("gap_out%0d", i), at(q4, i), e4[i]);
        chk("gap_done_last", (d4.size() == 4) ? d4[3] : -1, 1);
        chk("gap_done_cnt", dc4, 1);
        q4.delete(); d4.delete();

        // 3x3 odd map: one output per frame, trailing samples consumed
        dc3 = 0;
        for (int i = 1; i <= 9; i++) send(3, i);
        idle(2);
        chk("odd_count", q3.size(), 1);
        chk("odd_out", at(q3, 0), 5);
        chk("odd_done", (d3.size() == 1) ? d3[0] : -1, 1);
        q3.delete(); d3.delete();
        for (int i = 10; i <= 18; i++) send(3, i);
        idle(2);
        chk("odd2_count", q3.size(), 1);
        chk("odd2_out", at(q3, 0), 14);
        chk("odd_done_cnt", dc3, 2);
        q3.delete(); d3.delete();

        // Mid-frame reset on 4x4; the sample presented during reset is dropped
        for (int i = 100; i < 106; i++) send(4, i);
        pix4 = W'(200);
        v4   = 1'b1;
        rst  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        v4  = 1'b0;
        chk("mid_rst_out", longint'(po4), 0);
        chk("mid_rst_vld", longint'(pv4), 0);
        q4.delete(); d4.delete();
        dc4 = 0;
        for (int i = 0; i < 16; i++) send(4, i);
        idle(3);
        chk("mid_count", q4.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("mid_out%0d", i), at(q4, i), e4[i]);
        chk("mid_done_cnt", dc4, 1);
        q4.delete(); d4.delete();

        // Two back-to-back 4x4 frames, no idle cycle between them
        dc4 = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 16; i++) send(4, f * 16 + i);
        idle(3);
        chk("b2b_count", q4.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("b2b_out%0d", i), at(q4, i), e8[i]);
        chk("b2b_done_cnt", dc4, 2);
        chk("b2b_done_f0", (d4.size() == 8) ? d4[3] : -1, 1);
        chk("b2b_done_f1", (d4.size() == 8) ? d4[7] : -1, 1);
        chk("b2b_nodone_mid", (d4.size() == 8) ? d4[2] : -1, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
